// File: rtl/sseg_scan_mux_if.sv
// Bundle between a pattern generator and the scan multiplexer: pattern/strobe
// inputs toward the mux, multiplexed display pins and status back out.
interface sseg_scan_mux_if;
  // load is a one-cycle capture strobe with no ready: every cycle where load=1
  // is accepted, either into staging or (at a frame boundary) straight into
  // the shadow register.
  logic [6:0] in0;
  logic [6:0] in1;
  logic [6:0] in2;
  logic [6:0] in3;
  logic [3:0] dp_in;
  logic       load;
  logic [3:0] blank;
  logic [3:0] an;
  logic [6:0] sseg;
  logic       dp;
  logic       frame_tick;
  logic       pending;

  modport master (
    output in0, in1, in2, in3, dp_in, load, blank,
    input  an, sseg, dp, frame_tick, pending
  );

  modport slave (
    input  in0, in1, in2, in3, dp_in, load, blank,
    output an, sseg, dp, frame_tick, pending
  );
endinterface

// File: rtl/sseg_scan_mux.sv
// Four-digit seven-segment scan multiplexer with frame-synchronous double
// buffering and a per-slot anode guard interval against ghosting.
module sseg_scan_mux #(
  parameter int REFRESH_BITS = 18,
  parameter int GUARD_CYCLES = 16
) (
  input logic           clk,
  input logic           reset,
  sseg_scan_mux_if.slave bus
);
  localparam int N = REFRESH_BITS;
  localparam logic [N-3:0] GUARD = GUARD_CYCLES[N-3:0];
  localparam logic [N-1:0] ONE   = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0] cnt;
  logic [1:0]   slot;
  logic [N-3:0] off;
  logic         boundary;
  logic         dark;

  logic [6:0] live_seg [4];
  logic [6:0] stg_seg  [4];
  logic [3:0] stg_dp;
  logic [6:0] shd_seg  [4];
  logic [3:0] shd_dp;

  logic [3:0] an_q;
  logic [6:0] sseg_q;
  logic       dp_q;
  logic       tick_q;
  logic       pending_q;

  assign slot     = cnt[N-1:N-2];
  assign off      = cnt[N-3:0];
  assign boundary = &cnt;
  assign dark     = (off < GUARD) || bus.blank[slot];

  always_comb begin
    live_seg[0] = bus.in0;
    live_seg[1] = bus.in1;
    live_seg[2] = bus.in2;
    live_seg[3] = bus.in3;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      an_q      <= 4'b1111;
      sseg_q    <= 7'b1111111;
      dp_q      <= 1'b1;
      tick_q    <= 1'b0;
      pending_q <= 1'b0;
      stg_dp    <= 4'b1111;
      shd_dp    <= 4'b1111;
      for (int i = 0; i < 4; i++) begin
        stg_seg[i] <= 7'b1111111;
        shd_seg[i] <= 7'b1111111;
      end
    end else begin
      cnt    <= cnt + ONE;
      tick_q <= boundary;

      // A load coinciding with the boundary bypasses staging so it is not lost.
      if (boundary) begin
        if (bus.load) begin
          shd_seg <= live_seg;
          shd_dp  <= bus.dp_in;
        end else if (pending_q) begin
          shd_seg <= stg_seg;
          shd_dp  <= stg_dp;
        end
        pending_q <= 1'b0;
      end else if (bus.load) begin
        stg_seg   <= live_seg;
        stg_dp    <= bus.dp_in;
        pending_q <= 1'b1;
      end

      if (dark) begin
        an_q   <= 4'b1111;
        sseg_q <= 7'b1111111;
        dp_q   <= 1'b1;
      end else begin
        an_q   <= ~(4'b0001 << slot);
        sseg_q <= shd_seg[slot];
        dp_q   <= shd_dp[slot];
      end
    end
  end

  assign bus.an         = an_q;
  assign bus.sseg       = sseg_q;
  assign bus.dp         = dp_q;
  assign bus.frame_tick = tick_q;
  assign bus.pending    = pending_q;
endmodule

// File: doc/sseg_scan_mux.md
Name: sseg_scan_mux

Overview:
- Downstream display stage for the four-digit seven-segment board.
- Accepts four per-digit segment patterns and decimal points from a pattern generator, such as the rotating-square logic.
- Double-buffers those patterns and applies them only at frame boundaries, so the display never tears.
- Time-multiplexes the digits onto the shared active-low sseg/an pins, with a guard interval per slot to suppress ghosting.

Parameters:
- REFRESH_BITS, 18, refresh counter width N. Each digit slot lasts 2^(N-2) clk cycles. At 50 MHz a frame is about 5.24 ms. Legal range is N >= 4.
- GUARD_CYCLES, 16, cycles at the start of each slot with all anodes off. Must be less than 2^(N-2).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in0  in  7  digit 0 pattern (rightmost digit), {g,f,e,d,c,b,a}, active-low.
- in1  in  7  digit 1 pattern.
- in2  in  7  digit 2 pattern.
- in3  in  7  digit 3 pattern (leftmost digit).
- dp_in  in  4  decimal points, active-low; bit i belongs to digit i.
- load  in  1  capture strobe for in0..in3 and dp_in.
- blank  in  4  live per-digit blank mask; 1 means the digit is dark. Not buffered.
- an  out  4  anode enables, active-low; an[i] drives digit i.
- sseg  out  7  segment outputs, active-low, {g,f,e,d,c,b,a}.
- dp  out  1  decimal point, active-low.
- frame_tick  out  1  one-cycle pulse marking the first cycle of a new frame.
- pending  out  1  staged data is waiting for the next frame boundary.

Behaviour:
- Reset values (synchronous, active-high), taking effect on the next edge:
  - cnt = 0.
  - an = 4'b1111, sseg = 7'b1111111, dp = 1.
  - frame_tick = 0, pending = 0.
  - Staging and shadow registers all 1 (dark).
  - Any data staged before reset is discarded.
- Refresh counter:
  - cnt is N bits and increments by 1 every cycle, wrapping from 2^N-1 to 0.
  - Slot index: i = cnt[N-1:N-2].
  - Offset within slot: off = cnt[N-3:0].
- Boundary condition: B = (cnt == 2^N-1).
- Staging register:
  - load=1 with B=0: staging <= {in3..in0, dp_in} and pending <= 1.
  - Repeated loads before the boundary overwrite the staging register; the last load wins.
- Shadow register, updated when B=1:
  - If load=1 in that same cycle, the shadow takes the live inputs directly (bypass).
  - Otherwise, if pending=1, the shadow takes the staging register.
  - Otherwise the shadow is unchanged.
  - pending <= 0 in all three cases.
- Frame tick: frame_tick <= B, so it is high in the cycle where cnt == 0.
- Registered outputs (one cycle of latency from cnt):
  - If off < GUARD_CYCLES, or blank[i] == 1: an = 1111, sseg = 1111111, dp = 1.
  - Otherwise: an = ~(4'b0001 << i), sseg = shadow_seg[i], dp = shadow_dp[i].
- Visibility of new data: the first cycle that can show new shadow data is the cycle after frame_tick. That cycle falls inside digit 0's guard window when GUARD_CYCLES > 0.
- blank takes effect one cycle after it changes, mid-frame included.
- No combinational path from any input to any output.

Test Plan:
- Reset (REFRESH_BITS=6, GUARD_CYCLES=2):
  - Stimulus: hold reset 3 cycles, then release.
  - Required: an=1111, sseg=1111111, dp=1 throughout reset; pending=0; frame_tick=0.
  - Required: first frame_tick exactly 64 cycles after the release edge.
- Load and scan:
  - Stimulus: pulse load with in0=0011100, in1=0100011, in2=1111110, in3=0000000, dp_in=1110 mid-frame.
  - Required: pending=1 until the boundary; display stays dark (shadow all-off).
  - Required: next frame, slot 0 cycles 3..16 after frame_tick show an=1110, sseg=0011100, dp=0.
  - Required: slot 3 shows an=0111, sseg=0000000, dp=1.
- Guard interval:
  - Stimulus: any loaded patterns.
  - Required: in every slot, the first 2 output cycles have an=1111; an is never two-hot or all-zero.
- Last-wins and boundary bypass:
  - Stimulus: load in0=1000000, then load in0=1111001 before the boundary.
  - Required: frame shows 1111001.
  - Stimulus: load in0=0100100 exactly at cnt=63.
  - Required: the following frame shows 0100100; pending=0.
- Blank mask:
  - Stimulus: set blank=0100 mid-frame.
  - Required: during slot 2, an=1111 and sseg=1111111.
  - Required: other slots unaffected; clearing blank restores digit 2 one cycle later.
- Reset mid-operation:
  - Stimulus: load with pending=1, then assert reset at cnt=40.
  - Required: next edge gives cnt=0, pending=0, and all outputs dark.
  - Required: staged data never appears after reset release.
